// File: rtl/puck_physics.sv
// puck_physics: per-tick puck motion with wall and paddle bounces,
// goal detection, scoring and serve hold (raw hc/vc coordinates).
module puck_physics #(
    parameter int X_MIN       = 205,
    parameter int X_MAX       = 723,
    parameter int Y_MIN       = 82,
    parameter int Y_MAX       = 460,
    parameter int X_CTR       = 464,
    parameter int Y_CTR       = 271,
    parameter int GOAL_Y0     = 211,
    parameter int GOAL_Y1     = 331,
    parameter int HIT_R2      = 625,
    parameter int INIT_VX     = 7,
    parameter int INIT_VY     = 3,
    parameter int MAX_SPEED   = 12,
    parameter int SERVE_TICKS = 30,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       i_tick,
    input  logic [9:0] i_paddle1_x,
    input  logic [9:0] i_paddle1_y,
    input  logic [9:0] i_paddle2_x,
    input  logic [9:0] i_paddle2_y,
    output logic [9:0] o_puck_x,
    output logic [9:0] o_puck_y,
    output logic       o_busy,
    output logic       o_goal_p1,
    output logic       o_goal_p2,
    output logic [3:0] o_score_p1,
    output logic [3:0] o_score_p2,
    output logic       o_game_over
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STEP   = 3'd1;
    localparam logic [2:0] S_HIT    = 3'd2;
    localparam logic [2:0] S_RES    = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam logic signed [10:0] L_XMIN = 11'(X_MIN);
    localparam logic signed [10:0] L_XMAX = 11'(X_MAX);
    localparam logic signed [10:0] L_YMIN = 11'(Y_MIN);
    localparam logic signed [10:0] L_YMAX = 11'(Y_MAX);
    localparam logic signed [4:0]  L_IVX  = 5'(INIT_VX);
    localparam logic signed [4:0]  L_IVY  = 5'(INIT_VY);
    localparam logic [4:0]         L_MAXV = 5'(MAX_SPEED);
    localparam logic [21:0]        L_R2   = 22'(HIT_R2);
    localparam logic [3:0]         L_WIN  = 4'(WIN_SCORE);
    localparam logic [4:0]         L_SRV  = 5'(SERVE_TICKS);

    // Bounce off a paddle: magnitude +1 (saturating), sign away from paddle.
    function automatic logic signed [4:0] f_bump(
        input logic signed [4:0]  v,
        input logic signed [10:0] d
    );
        logic [4:0] m;
        logic       neg;
        m   = v[4] ? (~v + 5'd1) : v;
        m   = (m >= L_MAXV) ? L_MAXV : m + 5'd1;
        neg = (d == 11'sd0) ? ~v[4] : d[10];
        return neg ? $signed(~m + 5'd1) : $signed(m);
    endfunction

    function automatic logic [21:0] f_sq(input logic signed [10:0] d);
        logic signed [21:0] e;
        e = {{11{d[10]}}, d};
        return 22'(e * e);
    endfunction

    logic [2:0]         r_state;
    logic [9:0]         r_px, r_py;
    logic signed [4:0]  r_vx, r_vy, r_nvx, r_nvy;
    logic signed [10:0] r_nx, r_ny, r_dx, r_dy;
    logic               r_g1, r_g2, r_gp1, r_gp2;
    logic [1:0]         r_hit, r_cool;
    logic [4:0]         r_serve;
    logic [3:0]         r_s1, r_s2;

    logic signed [10:0] w_sx, w_sy, w_rx, w_ry;
    logic signed [4:0]  w_rvx, w_rvy;
    logic               w_g1, w_g2, w_band;
    logic signed [10:0] w_d1x, w_d1y, w_d2x, w_d2y;
    logic [21:0]        w_r1, w_r2;
    logic               w_h1, w_h2, w_over;

    // Advance by one velocity step and fold back off the rails or flag a goal.
    always_comb begin
        w_sx   = {1'b0, r_px} + {{6{r_vx[4]}}, r_vx};
        w_sy   = {1'b0, r_py} + {{6{r_vy[4]}}, r_vy};
        w_band = (r_py >= 10'(GOAL_Y0)) && (r_py <= 10'(GOAL_Y1));
        w_rx   = w_sx;
        w_ry   = w_sy;
        w_rvx  = r_vx;
        w_rvy  = r_vy;
        w_g1   = 1'b0;
        w_g2   = 1'b0;
        if (w_sx < L_XMIN) begin
            if (w_band) begin
                w_g2 = 1'b1;
            end else begin
                w_rx  = L_XMIN + (L_XMIN - w_sx);
                w_rvx = -r_vx;
            end
        end else if (w_sx > L_XMAX) begin
            if (w_band) begin
                w_g1 = 1'b1;
            end else begin
                w_rx  = L_XMAX - (w_sx - L_XMAX);
                w_rvx = -r_vx;
            end
        end
        if (w_sy < L_YMIN) begin
            w_ry  = L_YMIN + (L_YMIN - w_sy);
            w_rvy = -r_vy;
        end else if (w_sy > L_YMAX) begin
            w_ry  = L_YMAX - (w_sy - L_YMAX);
            w_rvy = -r_vy;
        end
    end

    assign w_d1x  = r_nx - $signed({1'b0, i_paddle1_x});
    assign w_d1y  = r_ny - $signed({1'b0, i_paddle1_y});
    assign w_d2x  = r_nx - $signed({1'b0, i_paddle2_x});
    assign w_d2y  = r_ny - $signed({1'b0, i_paddle2_y});
    assign w_r1   = f_sq(w_d1x) + f_sq(w_d1y);
    assign w_r2   = f_sq(w_d2x) + f_sq(w_d2y);
    assign w_h1   = (w_r1 < L_R2) && (r_cool != 2'd1);
    assign w_h2   = (w_r2 < L_R2) && (r_cool != 2'd2);
    assign w_over = (r_s1 == L_WIN) || (r_s2 == L_WIN);

    // Step sequencer: IDLE -> STEP -> HIT -> RESOLVE -> COMMIT.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_px    <= 10'(X_CTR);
            r_py    <= 10'(Y_CTR);
            r_vx    <= L_IVX;
            r_vy    <= L_IVY;
            r_nx    <= '0;
            r_ny    <= '0;
            r_nvx   <= '0;
            r_nvy   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
            r_gp1   <= 1'b0;
            r_gp2   <= 1'b0;
            r_hit   <= 2'd0;
            r_cool  <= 2'd0;
            r_serve <= 5'd0;
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
        end else begin
            r_gp1 <= 1'b0;
            r_gp2 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tick && !w_over) begin
                        if (r_serve != 5'd0) r_serve <= r_serve - 5'd1;
                        else                 r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_nx    <= w_rx;
                    r_ny    <= w_ry;
                    r_nvx   <= w_rvx;
                    r_nvy   <= w_rvy;
                    r_g1    <= w_g1;
                    r_g2    <= w_g2;
                    r_state <= S_HIT;
                end
                S_HIT: begin
                    r_hit   <= w_h1 ? 2'd1 : (w_h2 ? 2'd2 : 2'd0);
                    r_dx    <= w_h1 ? w_d1x : w_d2x;
                    r_dy    <= w_h1 ? w_d1y : w_d2y;
                    r_state <= S_RES;
                end
                S_RES: begin
                    if (!r_g1 && !r_g2 && r_hit != 2'd0) begin
                        r_nvx <= f_bump(r_nvx, r_dx);
                        r_nvy <= f_bump(r_nvy, r_dy);
                    end
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (r_g1 || r_g2) begin
                        r_gp1   <= r_g1;
                        r_gp2   <= r_g2;
                        if (r_g1 && r_s1 != L_WIN) r_s1 <= r_s1 + 4'd1;
                        if (r_g2 && r_s2 != L_WIN) r_s2 <= r_s2 + 4'd1;
                        r_px    <= 10'(X_CTR);
                        r_py    <= 10'(Y_CTR);
                        r_vx    <= r_g2 ? -L_IVX : L_IVX;
                        r_vy    <= L_IVY;
                        r_serve <= L_SRV;
                        r_cool  <= 2'd0;
                    end else begin
                        r_px   <= r_nx[9:0];
                        r_py   <= r_ny[9:0];
                        r_vx   <= r_nvx;
                        r_vy   <= r_nvy;
                        r_cool <= r_hit;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_puck_x    = r_px;
    assign o_puck_y    = r_py;
    assign o_busy      = (r_state != S_IDLE);
    assign o_goal_p1   = r_gp1;
    assign o_goal_p2   = r_gp2;
    assign o_score_p1  = r_s1;
    assign o_score_p2  = r_s2;
    assign o_game_over = w_over;
endmodule
